// File: rtl/ws2812_frame_reader_pkg.sv
// ws2812_frame_reader_pkg
//   Shared definitions for the WS2812 frame reader:
//   - default timing constants (50 MHz clk_sys basis)
//   - FSM state encoding
//   - RGB -> GRB reorder helper (WS2812 expects green first on the wire)
package ws2812_frame_reader_pkg;

    localparam int DEF_NUM_LEDS  = 500;
    localparam int DEF_ADDR_W    = 9;
    localparam int DEF_T0H_CYC   = 20;
    localparam int DEF_T1H_CYC   = 40;
    localparam int DEF_BIT_CYC   = 62;
    localparam int DEF_RESET_CYC = 15000;

    localparam int PIXEL_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SEND  = 3'd2,
        ST_STALL = 3'd3,
        ST_LATCH = 3'd4
    } state_e;

    // Buffer holds {R,G,B}; the strip wants {G,R,B}.
    function automatic logic [PIXEL_W-1:0] rgb_to_grb(input logic [PIXEL_W-1:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_frame_reader_if.sv
// ws2812_frame_reader_if
//   Frame-buffer read port.
//   rd_addr : pixel address (reader -> buffer)
//   rd_en   : single-cycle read request (reader -> buffer)
//   rd_data : {R,G,B} pixel (buffer -> reader)
//   rd_dv   : single-cycle data valid, any latency after rd_en (buffer -> reader)
interface ws2812_frame_reader_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [23:0]       rd_data;
    logic              rd_dv;

    modport master (
        output rd_addr,
        output rd_en,
        input  rd_data,
        input  rd_dv
    );

    modport slave (
        input  rd_addr,
        input  rd_en,
        output rd_data,
        output rd_dv
    );
endinterface

// File: rtl/ws2812_frame_reader_bit_encoder.sv
// ws2812_frame_reader_bit_encoder
//   Shifts a 24-bit word out MSB first with WS2812 NRZ timing.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     load       : take word; its first bit starts high on the next cycle
//     word       : 24-bit word already in wire order
//     dout       : registered serial output
//     word_done  : high in the last cycle of the last bit; a load in that
//                  same cycle continues with no gap
module ws2812_frame_reader_bit_encoder
    import ws2812_frame_reader_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PIXEL_W-1:0] word,
    output logic               dout,
    output logic               word_done
);

    localparam int CNT_W = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BIT_CYC - 1);
    // Bit-period counter runs down from CNT_TOP; the line is high while the
    // count is at or above these thresholds.
    localparam logic [CNT_W-1:0] HI0_TH  = CNT_W'(BIT_CYC - T0H_CYC);
    localparam logic [CNT_W-1:0] HI1_TH  = CNT_W'(BIT_CYC - T1H_CYC);

    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         bits_left_q, bits_left_d;
    logic               active_q, active_d;
    logic               dout_q, dout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            bits_left_q <= '0;
            active_q    <= 1'b0;
            dout_q      <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            bits_left_q <= bits_left_d;
            active_q    <= active_d;
            dout_q      <= dout_d;
        end
    end

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        bits_left_d = bits_left_q;
        active_d    = active_q;
        word_done   = 1'b0;

        if (active_q) begin
            if (cnt_q == '0) begin
                if (bits_left_q == '0) begin
                    word_done = 1'b1;
                    active_d  = 1'b0;
                end else begin
                    shift_d     = {shift_q[PIXEL_W-2:0], 1'b0};
                    bits_left_d = bits_left_q - 1'b1;
                    cnt_d       = CNT_TOP;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (load) begin
            shift_d     = word;
            cnt_d       = CNT_TOP;
            bits_left_d = 5'd23;
            active_d    = 1'b1;
        end

        // Output is computed from next state so the pin comes straight off a flop.
        dout_d = active_d && (cnt_d >= (shift_d[PIXEL_W-1] ? HI1_TH : HI0_TH));
    end

    assign dout = dout_q;

endmodule

// File: rtl/ws2812_frame_reader.sv
// ws2812_frame_reader
//   Reads NUM_LEDS pixels from the frame buffer and streams them to a WS2812
//   strip, then holds the line low for the latch period. The next pixel is
//   prefetched while the current one shifts so pixels go out back-to-back.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     start    : single-cycle frame request (ignored while busy)
//     busy     : frame in progress
//     done     : single-cycle pulse at end of latch period
//     rd_bus   : frame-buffer read port (master side)
//     dout     : WS2812 serial data
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | pixel 0 requested, waiting for rd_dv
//   SEND  | shifting a pixel; next pixel prefetched in the background
//   STALL | pixel finished before prefetch returned; line low
//   LATCH | line low for RESET_CYC cycles, then done
module ws2812_frame_reader
    import ws2812_frame_reader_pkg::*;
#(
    parameter int NUM_LEDS  = DEF_NUM_LEDS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int BIT_CYC   = DEF_BIT_CYC,
    parameter int RESET_CYC = DEF_RESET_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    ws2812_frame_reader_if.master rd_bus,
    output logic                  dout
);

    localparam int LATCH_W = $clog2(RESET_CYC + 1);
    localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUM_LEDS - 1);
    localparam logic [LATCH_W-1:0] LATCH_TOP = LATCH_W'(RESET_CYC - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pix_idx_q, pix_idx_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_en_q, rd_en_d;
    logic                pend_q, pend_d;
    logic [PIXEL_W-1:0]  next_buf_q, next_buf_d;
    logic                next_valid_q, next_valid_d;
    logic [LATCH_W-1:0]  latch_cnt_q, latch_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                enc_load;
    logic [PIXEL_W-1:0]  enc_word;
    logic                enc_word_done;
    logic [ADDR_W-1:0]   load_idx;
    logic                rd_accept;
    logic                cur_last;

    // Only data answering our own outstanding request is taken; this also
    // drops replies that were in flight across a reset.
    assign rd_accept = rd_bus.rd_dv && pend_q;
    assign cur_last  = (pix_idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pix_idx_q    <= '0;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            pend_q       <= 1'b0;
            next_buf_q   <= '0;
            next_valid_q <= 1'b0;
            latch_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_idx_q    <= pix_idx_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_q      <= rd_en_d;
            pend_q       <= pend_d;
            next_buf_q   <= next_buf_d;
            next_valid_q <= next_valid_d;
            latch_cnt_q  <= latch_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        pix_idx_d    = pix_idx_q;
        next_buf_d   = next_buf_q;
        next_valid_d = next_valid_q;
        latch_cnt_d  = latch_cnt_q;
        pend_d       = pend_q;

        if (enc_load) pix_idx_d = load_idx;
        if (rd_accept) pend_d = 1'b0;
        if (rd_en_d) pend_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    pix_idx_d    = '0;
                    next_valid_d = 1'b0;
                end
            end
            ST_FETCH: begin
                if (rd_accept) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (rd_accept && !enc_load) begin
                    next_buf_d   = rd_bus.rd_data;
                    next_valid_d = 1'b1;
                end
                if (enc_load) next_valid_d = 1'b0;
                if (enc_word_done) begin
                    if (cur_last) begin
                        state_d     = ST_LATCH;
                        latch_cnt_d = LATCH_TOP;
                    end else if (!enc_load) begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (rd_accept) state_d = ST_SEND;
            end
            ST_LATCH: begin
                if (latch_cnt_q == '0) state_d = ST_IDLE;
                else                   latch_cnt_d = latch_cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: encoder load, read requests, status flags
    always_comb begin
        enc_load  = 1'b0;
        enc_word  = '0;
        load_idx  = pix_idx_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_FETCH: begin
                if (rd_accept) begin
                    enc_load = 1'b1;
                    enc_word = rgb_to_grb(rd_bus.rd_data);
                    load_idx = pix_idx_q;
                end
            end
            ST_SEND: begin
                if (enc_word_done && !cur_last) begin
                    // A reply landing on the very last cycle is used directly.
                    if (next_valid_q) begin
                        enc_load = 1'b1;
                        enc_word = rgb_to_grb(next_buf_q);
                        load_idx = pix_idx_q + 1'b1;
                    end else if (rd_accept) begin
                        enc_load = 1'b1;
                        enc_word = rgb_to_grb(rd_bus.rd_data);
                        load_idx = pix_idx_q + 1'b1;
                    end
                end
            end
            ST_STALL: begin
                if (rd_accept) begin
                    enc_load = 1'b1;
                    enc_word = rgb_to_grb(rd_bus.rd_data);
                    load_idx = pix_idx_q + 1'b1;
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == '0) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Every pixel that starts shifting requests its successor, except the last.
        if (enc_load && (load_idx != LAST_IDX)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = load_idx + 1'b1;
        end
    end

    ws2812_frame_reader_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_bit_encoder (
        .clk       (clk),
        .rst       (rst),
        .load      (enc_load),
        .word      (enc_word),
        .dout      (dout),
        .word_done (enc_word_done)
    );

    assign rd_bus.rd_en   = rd_en_q;
    assign rd_bus.rd_addr = rd_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_ws2812_frame_reader.sv
// tb_ws2812_frame_reader
//   Self-checking bench: drives random frames through a frame-buffer model and
//   decodes the WS2812 line back into bits, comparing against the pixels.
module tb_ws2812_frame_reader;

    localparam int T0H   = 2;
    localparam int T1H   = 4;
    localparam int BITC  = 6;
    localparam int RST_C = 20;
    localparam int NL    = 3;
    localparam int AW    = 2;
    localparam int FRAME_LIMIT = 3000;

    logic clk = 1'b0;
    logic rst, start, start1;
    logic busy, done, dout;
    logic busy1, done1, dout1;

    int n_checks = 0;
    int n_pass   = 0;

    ws2812_frame_reader_if #(.ADDR_W(AW)) bus ();
    ws2812_frame_reader_if #(.ADDR_W(AW)) bus1 ();

    ws2812_frame_reader #(
        .NUM_LEDS(NL), .ADDR_W(AW), .T0H_CYC(T0H), .T1H_CYC(T1H),
        .BIT_CYC(BITC), .RESET_CYC(RST_C)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_bus(bus), .dout(dout)
    );

    ws2812_frame_reader #(
        .NUM_LEDS(1), .ADDR_W(AW), .T0H_CYC(T0H), .T1H_CYC(T1H),
        .BIT_CYC(BITC), .RESET_CYC(RST_C)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .rd_bus(bus1), .dout(dout1)
    );

    always #5 clk = ~clk;

    // Frame-buffer model: replies lat[addr] cycles after rd_en.
    typedef struct { int addr; int due; } req_t;
    logic [23:0] mem [4];
    int          lat [4];
    logic [23:0] mem1;
    int          mcyc = 0;
    int          stray_at = -1;
    req_t        rq[$];
    req_t        rq1[$];

    always @(posedge clk) begin
        #1;
        mcyc = mcyc + 1;
        bus.rd_dv  = 1'b0;
        bus1.rd_dv = 1'b0;
        if (rq.size() > 0 && rq[0].due <= mcyc) begin
            bus.rd_dv   = 1'b1;
            bus.rd_data = mem[rq[0].addr];
            void'(rq.pop_front());
        end else if (mcyc == stray_at) begin
            bus.rd_dv   = 1'b1;
            bus.rd_data = 24'hFFFFFF;
        end
        if (rq1.size() > 0 && rq1[0].due <= mcyc) begin
            bus1.rd_dv   = 1'b1;
            bus1.rd_data = mem1;
            void'(rq1.pop_front());
        end
        if (bus.rd_en)  rq.push_back('{int'(bus.rd_addr), mcyc + lat[bus.rd_addr]});
        if (bus1.rd_en) rq1.push_back('{0, mcyc + 3});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic sample(input bit sel, output bit d, output bit en, output int a,
                          output bit dv, output bit dn, output bit b);
        if (sel) begin
            d = dout1; en = bus1.rd_en; a = int'(bus1.rd_addr);
            dv = bus1.rd_dv; dn = done1; b = busy1;
        end else begin
            d = dout; en = bus.rd_en; a = int'(bus.rd_addr);
            dv = bus.rd_dv; dn = done; b = busy;
        end
    endtask

    // Runs one frame and checks it against the pixel contents of the model.
    task automatic run_frame(input string tag, input bit sel, input bit spam, input int stall_px);
        bit dq[$];
        bit got_bits[$];
        bit exp_bits[$];
        int addrs[$];
        int dvs[$];
        int rises[$];
        int n_px, rd_en_n, done_k, busy_err, post_act, bit_err, per_err, addr_err, w, last_rise;
        logic [23:0] px, grb;
        bit s_dout, s_en, s_dv, s_done, s_busy;
        int s_addr;

        n_px = sel ? 1 : NL;
        rd_en_n = 0; done_k = -1; busy_err = 0; post_act = 0;
        bit_err = 0; per_err = 0; addr_err = 0;

        if (sel) start1 = 1'b1; else start = 1'b1;
        for (int k = 0; k < FRAME_LIMIT && done_k < 0; k++) begin
            @(negedge clk);
            if (!spam) begin start = 1'b0; start1 = 1'b0; end
            sample(sel, s_dout, s_en, s_addr, s_dv, s_done, s_busy);
            dq.push_back(s_dout);
            if (s_en) begin rd_en_n++; addrs.push_back(s_addr); end
            if (s_dv) dvs.push_back(k);
            if (s_done) done_k = k;
            if (s_busy == s_done) busy_err++;
        end
        start = 1'b0; start1 = 1'b0;
        repeat (30) begin
            @(negedge clk);
            sample(sel, s_dout, s_en, s_addr, s_dv, s_done, s_busy);
            if (s_dout || s_en || s_done || s_busy) post_act++;
        end

        for (int p = 0; p < n_px; p++) begin
            px  = sel ? mem1 : mem[p];
            grb = {px[15:8], px[23:16], px[7:0]};
            for (int b = 23; b >= 0; b--) exp_bits.push_back(grb[b]);
        end

        for (int i = 0; i < dq.size(); i++) begin
            if (dq[i] && ((i == 0) ? 1'b1 : !dq[i-1])) begin
                rises.push_back(i);
                w = 0;
                while (i + w < dq.size() && dq[i+w]) w++;
                got_bits.push_back(w == T1H);
                if (w != T1H && w != T0H) bit_err++;
            end
        end
        for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++)
            if (got_bits[i] != exp_bits[i]) bit_err++;
        for (int i = 1; i < rises.size(); i++)
            if (i != 24 * stall_px && rises[i] - rises[i-1] != BITC) per_err++;
        for (int i = 0; i < addrs.size(); i++)
            if (addrs[i] != i) addr_err++;
        last_rise = (rises.size() > 0) ? rises[rises.size()-1] : -1000;

        chk({tag, "/rd_en_count"}, rd_en_n, n_px);
        chk({tag, "/rd_addr_seq"}, addr_err, 0);
        chk({tag, "/bit_count"}, rises.size(), 24 * n_px);
        chk({tag, "/bit_errs"}, bit_err, 0);
        chk({tag, "/first_rise"}, (rises.size() > 0) ? rises[0] : -1,
            (dvs.size() > 0) ? dvs[0] + 1 : -2);
        chk({tag, "/period_errs"}, per_err, 0);
        chk({tag, "/done_seen"}, int'(done_k >= 0), 1);
        chk({tag, "/done_at"}, done_k - last_rise, BITC + RST_C);
        chk({tag, "/busy_errs"}, busy_err, 0);
        chk({tag, "/post_idle"}, post_act, 0);
        if (stall_px > 0)
            chk({tag, "/stall_resume"},
                (rises.size() > 24 * stall_px) ? rises[24 * stall_px] : -1,
                (dvs.size() > stall_px) ? dvs[stall_px] + 1 : -2);
    endtask

    initial begin
        int act, n_dv;
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        mem1 = 24'h00FF00;
        for (int i = 0; i < 4; i++) begin mem[i] = '0; lat[i] = 3; end
        repeat (3) @(negedge clk);
        chk("reset/dout", dout, 0);
        chk("reset/busy", busy, 0);
        chk("reset/done", done, 0);
        chk("reset/rd_en", bus.rd_en, 0);
        chk("reset/rd_addr", bus.rd_addr, 0);
        chk("reset/dout1", dout1, 0);
        chk("reset/busy1", busy1, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Bit order and timing on a single-colour pixel
        mem[0] = 24'hFF0000; mem[1] = 24'($urandom); mem[2] = 24'($urandom);
        run_frame("order", 1'b0, 1'b0, -1);

        mem[0] = 24'h123456; mem[1] = 24'hABCDEF; mem[2] = 24'h000001;
        run_frame("frame", 1'b0, 1'b0, -1);

        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < NL; p++) begin
                mem[p] = 24'($urandom);
                lat[p] = int'($urandom_range(1, 12));
            end
            run_frame($sformatf("rand%0d", f), 1'b0, 1'b0, -1);
        end

        // Prefetch of pixel 1 is slow enough to force a stall
        for (int p = 0; p < NL; p++) begin mem[p] = 24'($urandom); lat[p] = 3; end
        lat[1] = 300;
        run_frame("stall", 1'b0, 1'b0, 1);
        lat[1] = 3;

        // start held high the whole frame
        for (int p = 0; p < NL; p++) mem[p] = 24'($urandom);
        run_frame("spam_start", 1'b0, 1'b1, -1);

        // Stray rd_dv while idle
        act = 0; n_dv = 0;
        stray_at = mcyc + 3;
        repeat (10) begin
            @(negedge clk);
            if (dout || busy || done || bus.rd_en) act++;
            if (bus.rd_dv) n_dv++;
        end
        chk("stray_dv/idle", act, 0);
        chk("stray_dv/seen", n_dv, 1);

        // Reset during bit 10 of pixel 1, with pixel 2 reply still in flight
        lat[2] = 200;
        start = 1'b1;
        for (int k = 0; k < 206; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid/dout", dout, 0);
        chk("rst_mid/busy", busy, 0);
        chk("rst_mid/rd_en", bus.rd_en, 0);
        act = 0; n_dv = 0;
        repeat (250) begin
            @(negedge clk);
            if (dout || busy || done || bus.rd_en) act++;
            if (bus.rd_dv) n_dv++;
        end
        chk("rst_mid/idle_after", act, 0);
        chk("rst_mid/late_dv", n_dv, 1);
        lat[2] = 3;
        for (int p = 0; p < NL; p++) mem[p] = 24'($urandom);
        run_frame("after_rst", 1'b0, 1'b0, -1);

        // Single-LED instance
        run_frame("one_led", 1'b1, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_reader.md
Name: ws2812_frame_reader

Overview:
Reads pixels out of the LED frame buffer, one pixel per read, using its read_en / read_address / data_dv interface. Serialises each 24-bit pixel onto a single WS2812 data line with cycle-counted NRZ timing. Ends the frame with a low latch period. Prefetches the next pixel while the current one is shifting, so pixels go out back-to-back with no gap.

Parameters:
NUM_LEDS, 500, pixels per frame; must be >= 1 and <= 2**ADDR_W.
ADDR_W, 9, frame-buffer address width.
T0H_CYC, 20, high time of a '0' bit, in clk cycles (0.4 us at 50 MHz).
T1H_CYC, 40, high time of a '1' bit, in clk cycles (0.8 us).
BIT_CYC, 62, total bit period, in clk cycles (1.25 us); must be > T1H_CYC > T0H_CYC > 0.
RESET_CYC, 15000, low latch time after the last bit (300 us).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
start  in  1  single-cycle request to send one frame.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  single-cycle pulse when the latch period ends.
rd_addr  out  ADDR_W  frame-buffer read address.
rd_en  out  1  single-cycle read request.
rd_data  in  24  pixel from buffer: [23:16]=R, [15:8]=G, [7:0]=B.
rd_dv  in  1  rd_data valid, single cycle, arbitrary latency after rd_en.
dout  out  1  WS2812 serial data line.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: dout=0, busy=0, done=0, rd_en=0, rd_addr=0; state IDLE; all counters and valid flags cleared.
- Reset mid-frame: dout=0 from the next edge, no done pulse, and any rd_dv arriving afterwards is ignored.
- States: IDLE -> FETCH -> SEND -> (STALL) -> LATCH -> IDLE.
- IDLE: when start=1, go to FETCH. On the next cycle rd_en=1, rd_addr=0, busy=1. start is ignored while busy=1.
- FETCH: wait for rd_dv. On rd_dv, load the shifter with {G,R,B} and enter SEND. The first dout rise is the cycle after rd_dv.
- SEND, on entry for pixel i with i < NUM_LEDS-1: pulse rd_en with rd_addr=i+1, one request only.
- SEND, prefetch capture: the returned rd_data goes into next_buf and sets next_valid.
- SEND, bit encoding: each bit lasts BIT_CYC cycles. dout is high for T1H_CYC cycles if the bit is 1, else T0H_CYC, then low for the rest of the period. Bits go MSB first: G7..G0, R7..R0, B7..B0.
- End of bit 24, more pixels and next_valid=1: load next_buf into the shifter, clear next_valid, start the next bit on the immediately following cycle (no gap), stay in SEND.
- End of bit 24, more pixels and next_valid=0: go to STALL with dout=0. On rd_dv, load and re-enter SEND. A stall longer than RESET_CYC latches the strip early; this is accepted.
- End of bit 24 of pixel NUM_LEDS-1: go to LATCH.
- LATCH: dout=0 for exactly RESET_CYC cycles. Then done=1 for one cycle, busy=0 in that same cycle, return to IDLE.
- rd_dv outside FETCH/STALL/outstanding prefetch: ignored. At most one read is outstanding at any time.
- NUM_LEDS=1: no prefetch is issued; exactly one rd_en per frame.
- rd_addr never exceeds NUM_LEDS-1 and never wraps within a frame.
- Width rules: pixel index is ADDR_W bits; bit-period counter is clog2(BIT_CYC) bits; latch counter is clog2(RESET_CYC+1) bits.

Decomposition:
- ws2812_pkg: default timing constants, state encoding localparams, and the RGB->GRB reorder function.
- Sub-module ws2812_bit_encoder:
  - inputs: 24-bit word, load strobe, timing parameters.
  - outputs: dout, word_done pulse.
  - The top level keeps the FSM, prefetch buffer and read handshake.

Test Plan:
Use T0H=2, T1H=4, BIT=6, RESET=20, NUM_LEDS=3, and a buffer model with 3-cycle rd_dv latency unless stated.
1. Order and timing: pixel0 = 0xFF0000 -> 8 bits with 2-cycle highs, then 8 with 4-cycle highs, then 8 with 2-cycle highs. Each period is exactly 6 cycles.
2. Frame: buffer = {0x123456, 0xABCDEF, 0x000001} -> rd_addr sequence 0,1,2 with exactly 3 rd_en pulses. 72 contiguous bit periods (432 cycles from the first rise), then 20 low cycles, then done. busy falls with done.
3. Stall: pixel 1 read latency = 300 cycles -> dout stays low after pixel 0 bit 24, resumes the cycle after rd_dv, and the total frame still carries 72 bits.
4. Reset mid-frame: rst during bit 10 of pixel 1 -> dout=0, busy=0, rd_en=0 next cycle. No done pulse. A late rd_dv is ignored and the next start begins at rd_addr 0.
5. Stray inputs: start pulsed every cycle while busy -> a single frame and a single done. rd_dv pulsed in IDLE -> no output activity.
6. NUM_LEDS=1, pixel 0x00FF00 -> one rd_en, first byte sent is G=0xFF, then 20-cycle latch, then done.
